// File: rtl/cert_chain_responder.sv
// cert_chain_responder
//   Answers GET_CERTIFICATE requests from a slot-organised chain store.
//   The block accepts one request and checks it. On a bad request it raises
//   a one-cycle error pulse. On a good request it streams a header beat, a
//   length beat ({portion, remainder}), and then the chain bytes. The bytes
//   are read one per cycle from an external byte store and packed MSB-first
//   into 32-bit beats.
//
// Ports
//   clk, reset       single clock, synchronous active-high reset
//   req_*            request handshake (slot, offset, length)
//   slot_present     per-slot provisioned flags (sampled at acceptance)
//   slot_chain_len   per-slot chain length, slot i at [16i+15:16i]
//   mem_rd_en/addr   byte-store read port; mem_rd_data returns one cycle later
//   out_*            answer stream (valid/ready, data, keep, last)
//   err_valid/code   one-cycle error pulse with its cause

`ifndef PROTOCOL_VERSION
`define PROTOCOL_VERSION 8'h12
`endif
`ifndef CERTIFICATE_ANSWER_CMD
`define CERTIFICATE_ANSWER_CMD 8'h02
`endif

module cert_chain_responder #(
    parameter int NUM_SLOTS   = 8,
    parameter int SLOT_BYTES  = 4096,
    parameter int MAX_PORTION = 1024,
    parameter int MEM_AW      = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [7:0]              req_slot,
    input  logic [15:0]             req_offset,
    input  logic [15:0]             req_length,
    input  logic [NUM_SLOTS-1:0]    slot_present,
    input  logic [16*NUM_SLOTS-1:0] slot_chain_len,
    output logic                    mem_rd_en,
    output logic [MEM_AW-1:0]       mem_addr,
    input  logic [7:0]              mem_rd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_data,
    output logic [3:0]              out_keep,
    output logic                    out_last,
    output logic                    err_valid,
    output logic [7:0]              err_code
);

    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_HDR, S_LENS, S_FETCH, S_STREAM
    } state_t;

    state_t state_q, state_d;

    // Request context captured at acceptance
    logic [7:0]        slot_q, slot_d;
    logic [15:0]       offset_q, offset_d;
    logic [15:0]       length_q, length_d;
    logic [15:0]       chain_len_q, chain_len_d;
    logic              present_q, present_d;
    logic [15:0]       portion_q, portion_d;
    logic [15:0]       remainder_q, remainder_d;

    // Fetch datapath
    logic [MEM_AW-1:0] addr_q, addr_d;       // next byte address to read
    logic [15:0]       left_q, left_d;       // bytes not yet packed into a beat
    logic [31:0]       pack_q, pack_d;       // beat under construction
    logic [1:0]        recv_q, recv_d;       // bytes already packed in this beat
    logic [2:0]        issued_q, issued_d;   // reads scheduled for this beat
    logic              rd_pend_q;            // mem_rd_data carries a byte this cycle

    // Registered outputs
    logic              mem_rd_en_q, mem_rd_en_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_data_q, out_data_d;
    logic [3:0]        out_keep_q, out_keep_d;
    logic              out_last_q, out_last_d;
    logic              err_valid_q, err_valid_d;
    logic [7:0]        err_code_q, err_code_d;

    // Per-slot chain length view of the flat input bus
    logic [15:0] slot_len_arr [NUM_SLOTS];
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot_len
        assign slot_len_arr[gi] = slot_chain_len[16*gi +: 16];
    end

    logic              req_slot_ok;
    logic [15:0]       sel_len;
    logic              sel_present;
    logic [7:0]        chk_code;
    logic [15:0]       avail;
    logic [15:0]       portion_c;
    logic [15:0]       remainder_c;
    logic [MEM_AW-1:0] base_addr;
    logic [2:0]        beat_n;
    logic              beat_done;
    logic [31:0]       pack_new;
    logic [3:0]        keep_c;
    logic              last_c;

    assign req_slot_ok = (int'(req_slot) < NUM_SLOTS);
    assign sel_len     = req_slot_ok ? slot_len_arr[req_slot[SLOT_W-1:0]] : 16'd0;
    assign sel_present = req_slot_ok && slot_present[req_slot[SLOT_W-1:0]];

    // Request checking and portion sizing (used in CHECK)
    always_comb begin
        avail     = chain_len_q - offset_q;
        portion_c = length_q;
        if (portion_c > 16'(MAX_PORTION)) begin
            portion_c = 16'(MAX_PORTION);
        end
        if (portion_c > avail) begin
            portion_c = avail;
        end
        remainder_c = avail - portion_c;
        if (!present_q) begin
            chk_code = 8'h01;
        end else if (length_q == 16'd0) begin
            chk_code = 8'h02;
        end else if (offset_q >= chain_len_q) begin
            chk_code = 8'h03;
        end else begin
            chk_code = 8'h00;
        end
    end

    // Storage address wraps at MEM_AW bits by construction
    assign base_addr = MEM_AW'(slot_q) * MEM_AW'(SLOT_BYTES) + MEM_AW'(offset_q);

    // Current beat size, and completion when its final byte returns
    assign beat_n    = (left_q >= 16'd4) ? 3'd4 : left_q[2:0];
    assign beat_done = rd_pend_q && (({1'b0, recv_q} + 3'd1) == beat_n);
    assign pack_new  = pack_q | ({mem_rd_data, 24'd0} >> {recv_q, 3'b000});
    assign last_c    = (left_q == 16'(beat_n));

    always_comb begin
        unique case (beat_n)
            3'd1:    keep_c = 4'b1000;
            3'd2:    keep_c = 4'b1100;
            3'd3:    keep_c = 4'b1110;
            default: keep_c = 4'b1111;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (req_valid) state_d = S_CHECK;
            S_CHECK:  state_d = (chk_code != 8'h00) ? S_IDLE : S_HDR;
            S_HDR:    if (out_ready) state_d = S_LENS;
            S_LENS:   if (out_ready) state_d = S_FETCH;
            S_FETCH:  if (beat_done) state_d = S_STREAM;
            S_STREAM: if (out_ready) state_d = out_last_q ? S_IDLE : S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM: outputs and datapath next values
    always_comb begin
        slot_d      = slot_q;
        offset_d    = offset_q;
        length_d    = length_q;
        chain_len_d = chain_len_q;
        present_d   = present_q;
        portion_d   = portion_q;
        remainder_d = remainder_q;
        addr_d      = addr_q;
        left_d      = left_q;
        pack_d      = pack_q;
        recv_d      = recv_q;
        issued_d    = issued_q;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        err_valid_d = 1'b0;
        err_code_d  = 8'h00;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    slot_d      = req_slot;
                    offset_d    = req_offset;
                    length_d    = req_length;
                    chain_len_d = sel_len;
                    present_d   = sel_present;
                end
            end
            S_CHECK: begin
                if (chk_code != 8'h00) begin
                    err_valid_d = 1'b1;
                    err_code_d  = chk_code;
                end else begin
                    portion_d   = portion_c;
                    remainder_d = remainder_c;
                    left_d      = portion_c;
                    addr_d      = base_addr;
                    pack_d      = 32'd0;
                    recv_d      = 2'd0;
                    issued_d    = 3'd0;
                    out_valid_d = 1'b1;
                    out_data_d  = {`PROTOCOL_VERSION, `CERTIFICATE_ANSWER_CMD, slot_q, 8'h00};
                    out_keep_d  = 4'hF;
                    out_last_d  = 1'b0;
                end
            end
            S_HDR: begin
                if (out_ready) begin
                    out_data_d = {portion_q, remainder_q};
                end
            end
            S_LENS: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (issued_q < beat_n) begin
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = addr_q;
                    addr_d      = addr_q + MEM_AW'(1);
                    issued_d    = issued_q + 3'd1;
                end
                if (beat_done) begin
                    out_valid_d = 1'b1;
                    out_data_d  = pack_new;
                    out_keep_d  = keep_c;
                    out_last_d  = last_c;
                    left_d      = left_q - 16'(beat_n);
                    pack_d      = 32'd0;
                    recv_d      = 2'd0;
                    issued_d    = 3'd0;
                end else if (rd_pend_q) begin
                    pack_d = pack_new;
                    recv_d = recv_q + 2'd1;
                end
            end
            S_STREAM: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q      <= 8'd0;
            offset_q    <= 16'd0;
            length_q    <= 16'd0;
            chain_len_q <= 16'd0;
            present_q   <= 1'b0;
            portion_q   <= 16'd0;
            remainder_q <= 16'd0;
            addr_q      <= '0;
            left_q      <= 16'd0;
            pack_q      <= 32'd0;
            recv_q      <= 2'd0;
            issued_q    <= 3'd0;
            rd_pend_q   <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
            out_keep_q  <= 4'd0;
            out_last_q  <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= 8'd0;
        end else begin
            slot_q      <= slot_d;
            offset_q    <= offset_d;
            length_q    <= length_d;
            chain_len_q <= chain_len_d;
            present_q   <= present_d;
            portion_q   <= portion_d;
            remainder_q <= remainder_d;
            addr_q      <= addr_d;
            left_q      <= left_d;
            pack_q      <= pack_d;
            recv_q      <= recv_d;
            issued_q    <= issued_d;
            rd_pend_q   <= mem_rd_en_q;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_cert_chain_responder.sv
// Testbench for cert_chain_responder: randomized requests and memory
// contents checked against a byte-queue reference model of the answer.

`ifndef PROTOCOL_VERSION
`define PROTOCOL_VERSION 8'h12
`endif
`ifndef CERTIFICATE_ANSWER_CMD
`define CERTIFICATE_ANSWER_CMD 8'h02
`endif

module tb_cert_chain_responder;

    localparam int NUM_SLOTS   = 8;
    localparam int SLOT_BYTES  = 4096;
    localparam int MAX_PORTION = 1024;
    localparam int MEM_AW      = 15;
    localparam int MEM_SIZE    = 1 << MEM_AW;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    req_valid = 1'b0;
    logic                    req_ready;
    logic [7:0]              req_slot = 8'd0;
    logic [15:0]             req_offset = 16'd0;
    logic [15:0]             req_length = 16'd0;
    logic [NUM_SLOTS-1:0]    slot_present = '0;
    logic [16*NUM_SLOTS-1:0] slot_chain_len = '0;
    logic                    mem_rd_en;
    logic [MEM_AW-1:0]       mem_addr;
    logic [7:0]              mem_rd_data = 8'd0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [31:0]             out_data;
    logic [3:0]              out_keep;
    logic                    out_last;
    logic                    err_valid;
    logic [7:0]              err_code;

    cert_chain_responder #(
        .NUM_SLOTS(NUM_SLOTS), .SLOT_BYTES(SLOT_BYTES),
        .MAX_PORTION(MAX_PORTION), .MEM_AW(MEM_AW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_slot(req_slot), .req_offset(req_offset), .req_length(req_length),
        .slot_present(slot_present), .slot_chain_len(slot_chain_len),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .out_last(out_last),
        .err_valid(err_valid), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Byte store: data valid exactly one cycle after the read strobe, junk otherwise
    logic [7:0] mem [MEM_SIZE];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
        else           mem_rd_data <= 8'($urandom);
    end

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    beat_t got_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Free-running monitor counters; tests look at differences across a window
    int err_cycles = 0;
    int last_err_code = 0;
    int ov_cycles = 0;
    int stall_viol = 0;
    int rd_while_pend = 0;

    logic        pv = 1'b0;
    logic [31:0] pd = 32'd0;
    logic [3:0]  pk = 4'd0;
    logic        pl = 1'b0;

    always begin
        @(posedge clk);
        #1;
        if (!reset) begin
            if (pv && !out_ready &&
                (out_valid !== 1'b1 || out_data !== pd || out_keep !== pk || out_last !== pl))
                stall_viol++;
            if (out_valid && mem_rd_en) rd_while_pend++;
            if (err_valid) begin
                err_cycles++;
                last_err_code = int'(err_code);
            end
            if (out_valid) ov_cycles++;
        end
        pv = out_valid;
        pd = out_data;
        pk = out_keep;
        pl = out_last;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] exp_err(input int s, input int o, input int l);
        int chain;
        if (s >= NUM_SLOTS) return 8'h01;
        if (!slot_present[s]) return 8'h01;
        if (l == 0) return 8'h02;
        chain = int'(slot_chain_len[16*s +: 16]);
        if (o >= chain) return 8'h03;
        return 8'h00;
    endfunction

    task automatic build_expected(input int s, input int o, input int l);
        int chain, avail, portion, rem;
        logic [7:0] bytes[$];
        beat_t b;
        exp_q.delete();
        chain   = int'(slot_chain_len[16*s +: 16]);
        avail   = chain - o;
        portion = l;
        if (portion > MAX_PORTION) portion = MAX_PORTION;
        if (portion > avail) portion = avail;
        rem = avail - portion;
        b.d = {`PROTOCOL_VERSION, `CERTIFICATE_ANSWER_CMD, 8'(s), 8'h00};
        b.k = 4'hF;
        b.l = 1'b0;
        exp_q.push_back(b);
        b.d = {16'(portion), 16'(rem)};
        exp_q.push_back(b);
        for (int i = 0; i < portion; i++)
            bytes.push_back(mem[MEM_AW'((s * SLOT_BYTES + o + i) % MEM_SIZE)]);
        for (int i = 0; i < portion; i += 4) begin
            b.d = 32'd0;
            b.k = 4'd0;
            for (int j = 0; j < 4; j++) begin
                if (i + j < portion) begin
                    b.d[31-8*j -: 8] = bytes[i+j];
                    b.k[3-j] = 1'b1;
                end
            end
            b.l = (i + 4 >= portion);
            exp_q.push_back(b);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_slot(input int s, input bit present, input int len);
        slot_present[s] = present;
        slot_chain_len[16*s +: 16] = 16'(len);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Presents a request and waits for it to be taken; returns at the
    // negedge after the accepting edge with request inputs scrambled.
    task automatic send_req(input int s, input int o, input int l, output bit to);
        int cyc = 0;
        to = 1'b0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_slot   = 8'(s);
        req_offset = 16'(o);
        req_length = 16'(l);
        while (!req_ready) begin
            @(negedge clk);
            cyc++;
            if (cyc > 200) begin
                to = 1'b1;
                break;
            end
        end
        @(negedge clk);
        req_valid  = 1'b0;
        req_slot   = 8'($urandom);
        req_offset = 16'($urandom);
        req_length = 16'($urandom);
    endtask

    // Collects answer beats until out_last (or max_beats when nonzero)
    task automatic collect(input int max_beats, input int ready_pct, output bit to,
                           output logic [MEM_AW-1:0] first_addr, output int n_acc);
        int cyc = 0;
        bit seen = 1'b0;
        beat_t b;
        got_q.delete();
        to = 1'b0;
        first_addr = '0;
        n_acc = 0;
        forever begin
            @(negedge clk);
            out_ready = ($urandom_range(99) < ready_pct);
            if (mem_rd_en && !seen) begin
                seen = 1'b1;
                first_addr = mem_addr;
            end
            if (req_valid && req_ready) n_acc++;
            if (out_valid && out_ready) begin
                b.d = out_data;
                b.k = out_keep;
                b.l = out_last;
                got_q.push_back(b);
                if (out_last || (max_beats > 0 && got_q.size() == max_beats)) break;
            end
            cyc++;
            if (cyc > 20000) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        wait_cycles(3);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_req_ready: got %b, expected 1", req_ready);
        end
        n_cmp++;
        if ({out_valid, out_last, out_keep, out_data, mem_rd_en, mem_addr, err_valid, err_code} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b last=%b keep=%h data=%h rd=%b addr=%h err=%b code=%h, expected all 0",
                     out_valid, out_last, out_keep, out_data, mem_rd_en, mem_addr, err_valid, err_code);
        end
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        bit to;
        logic [MEM_AW-1:0] fa;
        int na;
        out_ready = 1'b1;
        set_slot(0, 1'b1, 10);
        // full 10-byte chain, then a single byte at the last offset
        for (int c = 0; c < 2; c++) begin
            int o = (c == 0) ? 0 : 9;
            int l = (c == 0) ? 10 : 5;
            build_expected(0, o, l);
            send_req(0, o, l, to);
            collect(0, 100, to, fa, na);
            n_cmp++;
            if (to || got_q.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL basic%0d_beats: got %0d beats (timeout=%b), expected %0d", c, got_q.size(), to, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL basic%0d_beat%0d: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                             c, i, got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
                end
            end
            if (c == 0 && got_q.size() == 5) begin
                n_cmp++;
                if (got_q[1].d !== 32'h000A_0000 || got_q[4].k !== 4'hC || got_q[4].l !== 1'b1) begin
                    n_fail++;
                    $display("FAIL basic_v1_consts: got lens=%h keep=%h last=%b, expected lens=000a0000 keep=c last=1",
                             got_q[1].d, got_q[4].k, got_q[4].l);
                end
            end
            $display("test_basic case %0d: %0d beats", c, got_q.size());
        end
    endtask

    task automatic test_max_portion();
        bit to;
        logic [MEM_AW-1:0] fa;
        int na;
        set_slot(1, 1'b1, 3000);
        build_expected(1, 0, 2000);
        send_req(1, 0, 2000, to);
        collect(0, 100, to, fa, na);
        n_cmp++;
        if (to || got_q.size() != 258 || exp_q.size() != 258) begin
            n_fail++;
            $display("FAIL v2_beats: got %0d beats (timeout=%b), expected 258", got_q.size(), to);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL v2_beat%0d: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                         i, got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
            end
        end
        if (got_q.size() >= 2) begin
            n_cmp++;
            if (got_q[1].d !== 32'h0400_07B8) begin
                n_fail++;
                $display("FAIL v2_lens: got %h, expected 040007b8", got_q[1].d);
            end
        end
        $display("test_max_portion: %0d beats", got_q.size());
    endtask

    task automatic test_errors();
        int cases [6][4] = '{'{9, 0, 4, 1}, '{2, 0, 4, 1}, '{0, 0, 0, 2},
                             '{0, 10, 4, 3}, '{9, 20, 0, 1}, '{0, 12, 0, 2}};
        bit to;
        int e0, o0;
        set_slot(0, 1'b1, 10);
        set_slot(2, 1'b0, 100);
        for (int c = 0; c < 6; c++) begin
            e0 = err_cycles;
            o0 = ov_cycles;
            send_req(cases[c][0], cases[c][1], cases[c][2], to);
            wait_cycles(8);
            n_cmp++;
            if (to || err_cycles - e0 != 1 || last_err_code != cases[c][3]) begin
                n_fail++;
                $display("FAIL err%0d_pulse: got %0d err cycles code %0h, expected 1 cycle code %0h",
                         c, err_cycles - e0, last_err_code, cases[c][3]);
            end
            n_cmp++;
            if (ov_cycles - o0 != 0) begin
                n_fail++;
                $display("FAIL err%0d_no_out: got %0d out_valid cycles, expected 0", c, ov_cycles - o0);
            end
            $display("test_errors case %0d: slot=%0d code=%0h", c, cases[c][0], last_err_code);
        end
    endtask

    task automatic test_stall_offset();
        bit to;
        logic [MEM_AW-1:0] fa;
        int na, s0, r0;
        set_slot(3, 1'b1, 200);
        build_expected(3, 5, 150);
        s0 = stall_viol;
        r0 = rd_while_pend;
        send_req(3, 5, 150, to);
        collect(0, 50, to, fa, na);
        n_cmp++;
        if (fa !== 15'h3005) begin
            n_fail++;
            $display("FAIL v4_first_addr: got %h, expected 3005", fa);
        end
        n_cmp++;
        if (to || got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL v4_beats: got %0d beats (timeout=%b), expected %0d", got_q.size(), to, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL v4_beat%0d: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                         i, got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
            end
        end
        n_cmp++;
        if (stall_viol - s0 != 0 || rd_while_pend - r0 != 0) begin
            n_fail++;
            $display("FAIL v4_stall: got %0d unstable beats and %0d reads while pending, expected 0 and 0",
                     stall_viol - s0, rd_while_pend - r0);
        end
        $display("test_stall_offset: %0d beats first_addr=%h", got_q.size(), fa);
    endtask

    task automatic test_reset_mid();
        bit to;
        logic [MEM_AW-1:0] fa;
        int na, e0, o0;
        set_slot(1, 1'b1, 3000);
        send_req(1, 0, 2000, to);
        collect(4, 100, to, fa, na);
        n_cmp++;
        if (to || got_q.size() != 4) begin
            n_fail++;
            $display("FAIL v5_prefix: got %0d beats (timeout=%b), expected 4", got_q.size(), to);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, out_last, out_keep, out_data, mem_rd_en, mem_addr, err_valid, err_code} !== '0
            || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL v5_reset_outputs: got valid=%b last=%b keep=%h data=%h rd=%b addr=%h err=%b ready=%b, expected zeros and ready=1",
                     out_valid, out_last, out_keep, out_data, mem_rd_en, mem_addr, err_valid, req_ready);
        end
        reset = 1'b0;
        e0 = err_cycles;
        o0 = ov_cycles;
        wait_cycles(10);
        n_cmp++;
        if (err_cycles - e0 != 0 || ov_cycles - o0 != 0) begin
            n_fail++;
            $display("FAIL v5_quiet: got %0d err and %0d out_valid cycles after reset, expected 0", err_cycles - e0, ov_cycles - o0);
        end
        set_slot(0, 1'b1, 10);
        build_expected(0, 1, 7);
        send_req(0, 1, 7, to);
        collect(0, 100, to, fa, na);
        n_cmp++;
        if (to || got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL v5_after_beats: got %0d beats (timeout=%b), expected %0d", got_q.size(), to, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL v5_beat%0d: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                         i, got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
            end
        end
        $display("test_reset_mid: recovered answer %0d beats", got_q.size());
    endtask

    task automatic test_back_to_back();
        bit to;
        logic [MEM_AW-1:0] fa;
        int na, cyc, o0;
        set_slot(0, 1'b1, 10);
        build_expected(0, 2, 10);
        @(negedge clk);
        req_valid  = 1'b1;
        req_slot   = 8'd0;
        req_offset = 16'd2;
        req_length = 16'd10;
        cyc = 0;
        while (!req_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        collect(0, 60, to, fa, na);
        n_cmp++;
        if (to || na != 0 || got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL v6_first: got %0d beats, %0d extra accepts (timeout=%b), expected %0d beats 0 accepts",
                     got_q.size(), na, to, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL v6a_beat%0d: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                         i, got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL v6_ready_after_last: got %b, expected 1", req_ready);
        end
        // req_valid still high: this cycle's edge takes the second request
        @(negedge clk);
        req_valid = 1'b0;
        collect(0, 100, to, fa, na);
        n_cmp++;
        if (to || got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL v6_second: got %0d beats (timeout=%b), expected %0d", got_q.size(), to, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL v6b_beat%0d: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                         i, got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
            end
        end
        o0 = ov_cycles;
        wait_cycles(12);
        n_cmp++;
        if (ov_cycles - o0 != 0) begin
            n_fail++;
            $display("FAIL v6_no_third: got %0d out_valid cycles, expected 0", ov_cycles - o0);
        end
        $display("test_back_to_back: two answers of %0d beats", exp_q.size());
    endtask

    task automatic test_random();
        bit to;
        logic [MEM_AW-1:0] fa;
        int na, s, o, l, chain, e0, o0, s0;
        logic [7:0] ecode;
        for (int it = 0; it < 8; it++) begin
            for (int k = 0; k < NUM_SLOTS; k++)
                set_slot(k, 1'($urandom_range(1)), $urandom_range(4096, 1));
            s = ($urandom_range(9) == 0) ? $urandom_range(255, 8) : $urandom_range(NUM_SLOTS - 1);
            if (s < NUM_SLOTS && $urandom_range(4) != 0) slot_present[s] = 1'b1;
            chain = (s < NUM_SLOTS) ? int'(slot_chain_len[16*s +: 16]) : 100;
            o = ($urandom_range(7) == 0) ? chain + $urandom_range(3) : $urandom_range(chain - 1);
            l = ($urandom_range(9) == 0) ? 0 : $urandom_range(400, 1);
            ecode = exp_err(s, o, l);
            if (ecode == 8'h00) build_expected(s, o, l);
            e0 = err_cycles;
            o0 = ov_cycles;
            s0 = stall_viol;
            send_req(s, o, l, to);
            // configuration changes after acceptance must not matter
            slot_present   = NUM_SLOTS'($urandom);
            slot_chain_len = {4{32'($urandom)}};
            if (ecode != 8'h00) begin
                wait_cycles(8);
                n_cmp++;
                if (to || err_cycles - e0 != 1 || last_err_code != int'(ecode) || ov_cycles - o0 != 0) begin
                    n_fail++;
                    $display("FAIL rand%0d_err: got %0d err cycles code %0h, %0d out_valid cycles, expected 1 cycle code %0h, 0",
                             it, err_cycles - e0, last_err_code, ov_cycles - o0, ecode);
                end
            end else begin
                collect(0, 70, to, fa, na);
                n_cmp++;
                if (to || got_q.size() != exp_q.size() || stall_viol - s0 != 0) begin
                    n_fail++;
                    $display("FAIL rand%0d_beats: got %0d beats %0d unstable (timeout=%b), expected %0d beats 0 unstable",
                             it, got_q.size(), stall_viol - s0, to, exp_q.size());
                end
                for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                    n_cmp++;
                    if (got_q[i] !== exp_q[i]) begin
                        n_fail++;
                        $display("FAIL rand%0d_beat%0d: got data=%h keep=%h last=%b, expected data=%h keep=%h last=%b",
                                 it, i, got_q[i].d, got_q[i].k, got_q[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
                    end
                end
            end
            $display("test_random %0d: slot=%0d off=%0d len=%0d code=%0h", it, s, o, l, ecode);
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_max_portion();
        test_errors();
        test_stall_offset();
        test_reset_mid();
        test_back_to_back();
        test_random();
        n_cmp++;
        if (rd_while_pend != 0) begin
            n_fail++;
            $display("FAIL rd_while_pending: got %0d cycles, expected 0", rd_while_pend);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cert_chain_responder.md
CERT_CHAIN_RESPONDER -- requirements
Module: cert_chain_responder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the single clock, reset is synchronous and active-high.
REQ-002 Parameters SHALL be:
- NUM_SLOTS, 8, number of certificate-chain slots
- SLOT_BYTES, 4096, bytes of chain storage per slot
- MAX_PORTION, 1024, maximum chain bytes returned per answer
- MEM_AW, 15, storage byte-address width, >= clog2(NUM_SLOTS*SLOT_BYTES)
REQ-003 Ports SHALL be:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- req_valid  in  1  GET_CERTIFICATE request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_slot  in  8  Param1 slot number
- req_offset  in  16  byte offset into chain
- req_length  in  16  requested byte count
- slot_present  in  NUM_SLOTS  per-slot provisioned flag
- slot_chain_len  in  16*NUM_SLOTS  per-slot chain length in bytes; slot i at [16i+15:16i]
- mem_rd_en  out  1  storage read strobe
- mem_addr  out  MEM_AW  storage byte address
- mem_rd_data  in  8  storage byte, valid exactly 1 cycle after mem_rd_en
- out_valid  out  1  answer beat valid
- out_ready  in  1  downstream accepts beat
- out_data  out  32  answer beat, first byte in [31:24]
- out_keep  out  4  valid-byte mask, MSB = byte [31:24]
- out_last  out  1  final beat of answer
- err_valid  out  1  one-cycle error pulse
- err_code  out  8  error cause, valid with err_valid

Function
REQ-004 The FSM SHALL have states IDLE, CHECK, HDR, LENS, FETCH, STREAM; req_ready SHALL be 1 only in IDLE.
REQ-005 On acceptance the block SHALL register slot, offset, length, and the selected chain_len, then go to CHECK.
REQ-006 CHECK SHALL take 1 cycle, evaluated in priority order:
- slot >= NUM_SLOTS or !slot_present[slot]: err_code 0x01
- length == 0: err_code 0x02
- offset >= chain_len: err_code 0x03
- on error: err_valid pulses for 1 cycle, return to IDLE, no out_valid
- otherwise go to HDR
REQ-007 portion SHALL be min(length, MAX_PORTION, chain_len-offset), and remainder SHALL be chain_len-offset-portion; both are 16-bit and computed in CHECK.
REQ-008 The HDR beat SHALL be {`PROTOCOL_VERSION, `CERTIFICATE_ANSWER_CMD, slot, 8'h00}, with keep 4'hF and last 0.
REQ-009 The LENS beat SHALL be {portion, remainder}, with keep 4'hF; last SHALL be 0.
REQ-010 FETCH SHALL read bytes sequentially from mem_addr = slot*SLOT_BYTES + offset + i, for i = 0..portion-1, one byte per cycle, packing up to 4 bytes per beat MSB-first.
- The address arithmetic SHALL be done at MEM_AW width.
REQ-011 A data beat SHALL be presented in STREAM after its last byte returns.
- out_keep SHALL mark the packed bytes; unused bytes SHALL be 0.
- out_last SHALL be 1 on the beat containing byte portion-1.
REQ-012 All out_* SHALL be registered and held stable while out_valid && !out_ready.
- No mem_rd_en SHALL be issued while a beat is pending.
REQ-013 After the out_last beat is accepted, the FSM SHALL return to IDLE; req_ready SHALL be 1 in the following cycle.
REQ-014 Request inputs SHALL be ignored outside IDLE; slot_present and slot_chain_len SHALL be sampled only at acceptance.
REQ-015 A full answer SHALL be 2 + ceil(portion/4) beats; for portion = MAX_PORTION = 1024 that is 258 beats.

Reset
REQ-016 While reset is 1 at a clk edge, the following SHALL hold in the next cycle:
- FSM in IDLE
- req_ready 1
- out_valid, out_last, out_keep, out_data, mem_rd_en, mem_addr, err_valid, err_code all 0
REQ-017 Reset asserted mid-answer SHALL abort the answer with no out_last and no err_valid; the next request after reset SHALL be served from the start.

Verification
REQ-018 Test V1: slot 0 present, chain_len 10, offset 0, length 10 -> HDR, then LENS 0x000A_0000, then 3 data beats with keeps F, F, C; last on the third beat.
REQ-019 Test V2: chain_len 3000, offset 0, length 2000 -> LENS 0x0400_07B8 (portion 1024, remainder 1976); 256 data beats, last keep F.
REQ-020 Test V3: slot 9 -> err 0x01; slot 2 not present -> err 0x01; length 0 -> err 0x02; offset 10 with chain_len 10 -> err 0x03; each error is a 1-cycle pulse with out_valid never 1.
REQ-021 Test V4: slot 3, offset 5 -> first mem_addr = 3*4096+5 = 0x3005; out_ready toggled randomly -> data matches storage byte-exact; beats stable while stalled.
REQ-022 Test V5: reset pulsed after the 2nd data beat of V2 -> outputs zero next cycle; a new request is answered correctly.
REQ-023 Test V6: req_valid held high through an answer -> exactly one answer per handshake; back-to-back requests -> req_ready rises the cycle after out_last is accepted.
